// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch sequencer: bus/instruction types,
// FSM states and the prefetch FIFO payload.
package inst_fetch_ctrl_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned ILEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   typedef logic [XLEN-1:0] dataBus_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } r_type_t;

   typedef union packed {
      logic [ILEN-1:0] raw;
      r_type_t         r;
   } instruction_u;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_WAIT,
      S_FAULT
   } fetch_state_e;

   typedef struct packed {
      dataBus_t     pc;
      instruction_u instr;
   } fetch_entry_t;

   // Sequential fetch step; wraps silently at the top of the address space.
   function automatic dataBus_t next_pc(input dataBus_t pc);
      return pc + dataBus_t'(INST_BYTES);
   endfunction

   function automatic logic is_misaligned(input dataBus_t pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with synchronous flush.
// Head reads as all-zero while empty.
module inst_fetch_ctrl_fetch_fifo
   import inst_fetch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t wr_data_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Flush wins over any same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
         else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: drives the instruction memory, handles redirects, memory
// waits with timeout and sticky faults, and feeds decode through a prefetch FIFO.
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter dataBus_t    RESET_PC     = '0,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         clk_en,
   input  logic         rst_n,
   input  logic         redirect,
   input  dataBus_t     redirect_pc,
   output logic         mem_rd_en,
   output dataBus_t     mem_addr,
   input  instruction_u mem_instruction,
   input  logic         mem_ready,
   output logic         if_valid,
   input  logic         if_ready,
   output dataBus_t     if_pc,
   output instruction_u if_instruction,
   output logic         fetch_fault
);

   localparam int unsigned CNT_W = 8;

   fetch_state_e     state_q, state_d;
   dataBus_t         fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic         fifo_full, fifo_empty;
   logic         push, pop, flush, can_push;
   fetch_entry_t wr_entry, head;

   assign pop      = clk_en & !fifo_empty & if_ready;
   assign can_push = !fifo_full | pop;
   assign flush    = clk_en & redirect & (state_q != S_BOOT);
   assign wr_entry = '{pc: fetch_pc_q, instr: mem_instruction};

   assign mem_addr       = fetch_pc_q;
   assign if_valid       = !fifo_empty;
   assign if_pc          = head.pc;
   assign if_instruction = head.instr;
   assign fetch_fault    = (state_q == S_FAULT);

   // Next-state, fetch address, wait counter and memory strobe.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      wait_cnt_d = wait_cnt_q;
      mem_rd_en  = 1'b0;
      push       = 1'b0;
      if (clk_en) begin
         if (flush) begin
            fetch_pc_d = redirect_pc;
            wait_cnt_d = '0;
            state_d    = is_misaligned(redirect_pc) ? S_FAULT : S_FETCH;
         end else begin
            case (state_q)
               S_BOOT: state_d = S_FETCH;
               S_FETCH: begin
                  mem_rd_en = can_push;
                  if (can_push && mem_ready) begin
                     push       = 1'b1;
                     fetch_pc_d = next_pc(fetch_pc_q);
                  end else if (can_push) begin
                     wait_cnt_d = CNT_W'(1);
                     state_d    = (WAIT_TIMEOUT <= 1) ? S_FAULT : S_WAIT;
                  end
               end
               S_WAIT: begin
                  // Entry into the wait state guarantees a free FIFO slot.
                  mem_rd_en = 1'b1;
                  if (mem_ready) begin
                     push       = 1'b1;
                     fetch_pc_d = next_pc(fetch_pc_q);
                     wait_cnt_d = '0;
                     state_d    = S_FETCH;
                  end else begin
                     wait_cnt_d = wait_cnt_q + CNT_W'(1);
                     if (wait_cnt_d == CNT_W'(WAIT_TIMEOUT)) state_d = S_FAULT;
                  end
               end
               S_FAULT: state_d = S_FAULT;
               default: state_d = S_BOOT;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         wait_cnt_q <= '0;
      end else if (clk_en) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   inst_fetch_ctrl_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .push_i    (push),
      .pop_i     (pop),
      .wr_data_i (wr_entry),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (head)
   );

endmodule
